// File: rtl/pikarisc_pkg.sv
// Shared constants, types and helpers for the pikarisc operand-read stage.
package pikarisc_pkg;

  localparam int REG_NUM_W = 4;
  localparam int DATA_W    = 32;
  localparam int NUM_REGS  = 16;
  localparam int SB_SLOTS  = NUM_REGS + 1;
  localparam int SLOT_W    = $clog2(SB_SLOTS);
  localparam int NUM_SRC   = 3;
  localparam int STALL_W   = 16;

  // CPSR occupies the scoreboard slot just past the general registers.
  localparam logic [SLOT_W-1:0] CPSR_IDX = SLOT_W'(NUM_REGS);

  localparam int SRC_RD = 0;
  localparam int SRC_RS = 1;
  localparam int SRC_RT = 2;

  typedef struct packed {
    logic writes_rd;
    logic writes_cpsr;
    logic is_alu_op;
    logic is_cmp_op;
    logic is_ld_op;
  } op_flags_t;

  function automatic logic [SLOT_W-1:0] slot_of(input logic [REG_NUM_W-1:0] num);
    return SLOT_W'(num);
  endfunction

endpackage

// File: rtl/op_scoreboard.sv
// In-flight write counters for the 16 registers plus CPSR, with per-source
// busy/last/full queries for the operand-read stage.
module op_scoreboard
  import pikarisc_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              inc_rd_en,
  input  logic [REG_NUM_W-1:0]              inc_rd_num,
  input  logic                              inc_cpsr_en,
  input  logic                              dec_rd_en,
  input  logic [REG_NUM_W-1:0]              dec_rd_num,
  input  logic                              dec_cpsr_en,
  input  logic                              held_rd_en,
  input  logic [REG_NUM_W-1:0]              held_rd_num,
  input  logic                              held_cpsr_en,
  input  logic [NUM_SRC-1:0][REG_NUM_W-1:0] src_num,
  output logic [NUM_SRC-1:0]                busy,
  output logic [NUM_SRC-1:0]                last,
  output logic [NUM_SRC-1:0]                full,
  output logic                              cpsr_busy,
  output logic                              cpsr_last,
  output logic                              cpsr_full
);

  localparam logic [PEND_W-1:0] CNT_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] CNT_MAX  = '1;
  localparam logic [PEND_W-1:0] CNT_NEAR = CNT_MAX - CNT_ONE;

  logic [PEND_W-1:0]   cnt [SB_SLOTS];
  logic [SB_SLOTS-1:0] inc_vec;
  logic [SB_SLOTS-1:0] dec_vec;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    inc_vec = '0;
    dec_vec = '0;
    if (inc_rd_en)   inc_vec[slot_of(inc_rd_num)] = 1'b1;
    if (inc_cpsr_en) inc_vec[CPSR_IDX]            = 1'b1;
    if (dec_rd_en)   dec_vec[slot_of(dec_rd_num)] = 1'b1;
    if (dec_cpsr_en) dec_vec[CPSR_IDX]            = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all counters update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this array is reset (unlike a RAM) because stale reservations would stall forever.
      for (int i = 0; i < SB_SLOTS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < SB_SLOTS; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end else if (dec_vec[i] && !inc_vec[i] && cnt[i] != '0) begin
          cnt[i] <= cnt[i] - CNT_ONE;
        end
      end
    end
  end

  // "full" also counts the held instruction, whose reservation lands at handoff.
  always_comb begin
    busy = '0;
    last = '0;
    full = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      busy[s] = cnt[slot_of(src_num[s])] != '0;
      last[s] = cnt[slot_of(src_num[s])] == CNT_ONE;
      full[s] = (cnt[slot_of(src_num[s])] == CNT_MAX) ||
                (cnt[slot_of(src_num[s])] == CNT_NEAR && held_rd_en &&
                 held_rd_num == src_num[s]);
    end
    cpsr_busy = cnt[CPSR_IDX] != '0;
    cpsr_last = cnt[CPSR_IDX] == CNT_ONE;
    cpsr_full = (cnt[CPSR_IDX] == CNT_MAX) ||
                (cnt[CPSR_IDX] == CNT_NEAR && held_cpsr_en);
  end

endmodule

// File: rtl/operand_read.sv
// Operand-read stage: reads regFile, resolves RAW hazards via a scoreboard and
// feeds a one-entry register toward execute. OPREAD_BYPASS_EN enables the writeback bypass.
module operand_read
  import pikarisc_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_NUM_W-1:0] in_rd_num,
  input  logic [REG_NUM_W-1:0] in_rs_num,
  input  logic [REG_NUM_W-1:0] in_rt_num,
  input  logic                 in_uses_rd,
  input  logic                 in_uses_rs,
  input  logic                 in_uses_rt,
  input  logic                 in_uses_cpsr,
  input  logic                 in_writes_rd,
  input  logic                 in_writes_cpsr,
  input  logic                 in_is_alu_op,
  input  logic                 in_is_cmp_op,
  input  logic                 in_is_ld_op,
  output logic [REG_NUM_W-1:0] exe_rd_num,
  output logic [REG_NUM_W-1:0] exe_rs_num,
  output logic [REG_NUM_W-1:0] exe_rt_num,
  input  logic [DATA_W-1:0]    exe_rd_data_out,
  input  logic [DATA_W-1:0]    exe_rs_data_out,
  input  logic [DATA_W-1:0]    exe_rt_data_out,
  input  logic [DATA_W-1:0]    exe_cpsr_out,
  input  logic [REG_NUM_W-1:0] wb_rd_num,
  input  logic                 wb_rd_write_en,
  input  logic [DATA_W-1:0]    wb_rd_in,
  input  logic                 wb_cpsr_write_en,
  input  logic [DATA_W-1:0]    wb_cpsr_in,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_NUM_W-1:0] out_rd_num,
  output logic [DATA_W-1:0]    out_rd_val,
  output logic [DATA_W-1:0]    out_rs_val,
  output logic [DATA_W-1:0]    out_rt_val,
  output logic [DATA_W-1:0]    out_cpsr,
  output logic                 out_writes_rd,
  output logic                 out_writes_cpsr,
  output logic                 out_is_alu_op,
  output logic                 out_is_cmp_op,
  output logic                 out_is_ld_op,
  output logic [STALL_W-1:0]   hazard_stalls
);

`ifdef OPREAD_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  logic [NUM_SRC-1:0][REG_NUM_W-1:0] src_num;
  logic [NUM_SRC-1:0][DATA_W-1:0]    rf_data;
  logic [NUM_SRC-1:0][DATA_W-1:0]    src_val;
  logic [NUM_SRC-1:0]                src_used;
  logic [NUM_SRC-1:0]                held_wr;
  logic [NUM_SRC-1:0]                wb_hit;
  logic [NUM_SRC-1:0]                src_hazard;
  logic [NUM_SRC-1:0]                sb_busy, sb_last, sb_full;
  logic                              sb_cpsr_busy, sb_cpsr_last, sb_cpsr_full;
  logic                              cpsr_held_wr, cpsr_wb_hit, cpsr_hazard;
  logic [DATA_W-1:0]                 cpsr_val;
  logic                              hazard, pend_full, capture, handoff;
  op_flags_t                         in_flags, out_flags;

  assign exe_rd_num = in_rd_num;
  assign exe_rs_num = in_rs_num;
  assign exe_rt_num = in_rt_num;

  assign src_num  = {in_rt_num, in_rs_num, in_rd_num};
  assign rf_data  = {exe_rt_data_out, exe_rs_data_out, exe_rd_data_out};
  assign src_used = {in_uses_rt, in_uses_rs, in_uses_rd};

  assign in_flags = '{writes_rd:   in_writes_rd,
                      writes_cpsr: in_writes_cpsr,
                      is_alu_op:   in_is_alu_op,
                      is_cmp_op:   in_is_cmp_op,
                      is_ld_op:    in_is_ld_op};

  // Handoff is suppressed under flush so a discarded instruction never reserves.
  assign handoff = out_valid && out_ready && !flush;

  op_scoreboard #(.PEND_W(PEND_W)) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .inc_rd_en    (handoff && out_flags.writes_rd),
    .inc_rd_num   (out_rd_num),
    .inc_cpsr_en  (handoff && out_flags.writes_cpsr),
    .dec_rd_en    (wb_rd_write_en),
    .dec_rd_num   (wb_rd_num),
    .dec_cpsr_en  (wb_cpsr_write_en),
    .held_rd_en   (out_valid && out_flags.writes_rd),
    .held_rd_num  (out_rd_num),
    .held_cpsr_en (out_valid && out_flags.writes_cpsr),
    .src_num      (src_num),
    .busy         (sb_busy),
    .last         (sb_last),
    .full         (sb_full),
    .cpsr_busy    (sb_cpsr_busy),
    .cpsr_last    (sb_cpsr_last),
    .cpsr_full    (sb_cpsr_full)
  );

  // A bypass applies only when the writeback retires the single outstanding write.
  always_comb begin
    src_val    = rf_data;
    held_wr    = '0;
    wb_hit     = '0;
    src_hazard = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      held_wr[s]    = out_valid && out_flags.writes_rd && (out_rd_num == src_num[s]);
      wb_hit[s]     = BYPASS_EN && wb_rd_write_en && (wb_rd_num == src_num[s]) &&
                      sb_last[s] && !held_wr[s];
      src_hazard[s] = src_used[s] && (sb_busy[s] || held_wr[s]) && !wb_hit[s];
      if (wb_hit[s]) src_val[s] = wb_rd_in;
    end
    cpsr_held_wr = out_valid && out_flags.writes_cpsr;
    cpsr_wb_hit  = BYPASS_EN && wb_cpsr_write_en && sb_cpsr_last && !cpsr_held_wr;
    cpsr_hazard  = in_uses_cpsr && (sb_cpsr_busy || cpsr_held_wr) && !cpsr_wb_hit;
    cpsr_val     = cpsr_wb_hit ? wb_cpsr_in : exe_cpsr_out;
    hazard       = (|src_hazard) || cpsr_hazard;
  end

  assign pend_full = (in_writes_rd && sb_full[SRC_RD]) || (in_writes_cpsr && sb_cpsr_full);
  assign in_ready  = !reset && !hazard && !pend_full && (!out_valid || out_ready) && !flush;
  assign capture   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_rd_num <= '0;
      out_rd_val <= '0;
      out_rs_val <= '0;
      out_rt_val <= '0;
      out_cpsr   <= '0;
      out_flags  <= '0;
    end else if (capture) begin
      out_valid  <= 1'b1;
      out_rd_num <= in_rd_num;
      out_rd_val <= src_val[SRC_RD];
      out_rs_val <= src_val[SRC_RS];
      out_rt_val <= src_val[SRC_RT];
      out_cpsr   <= cpsr_val;
      out_flags  <= in_flags;
    end else if (flush || handoff) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hazard_stalls <= '0;
    end else if (in_valid && !in_ready && (hazard || pend_full) && hazard_stalls != '1) begin
      hazard_stalls <= hazard_stalls + STALL_W'(1);
    end
  end

  assign out_writes_rd   = out_flags.writes_rd;
  assign out_writes_cpsr = out_flags.writes_cpsr;
  assign out_is_alu_op   = out_flags.is_alu_op;
  assign out_is_cmp_op   = out_flags.is_cmp_op;
  assign out_is_ld_op    = out_flags.is_ld_op;

endmodule

// File: tb/tb_operand_read.sv
// Directed self-checking bench for operand_read with a small regFile model.
module tb_operand_read;
  import pikarisc_pkg::*;

`ifdef OPREAD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, in_ready;
  logic [3:0]  in_rd_num, in_rs_num, in_rt_num;
  logic        in_uses_rd, in_uses_rs, in_uses_rt, in_uses_cpsr;
  logic        in_writes_rd, in_writes_cpsr, in_is_alu_op, in_is_cmp_op, in_is_ld_op;
  logic [3:0]  exe_rd_num, exe_rs_num, exe_rt_num;
  logic [31:0] exe_rd_data_out, exe_rs_data_out, exe_rt_data_out, exe_cpsr_out;
  logic [3:0]  wb_rd_num;
  logic        wb_rd_write_en, wb_cpsr_write_en, flush, out_valid, out_ready;
  logic [31:0] wb_rd_in, wb_cpsr_in;
  logic [3:0]  out_rd_num;
  logic [31:0] out_rd_val, out_rs_val, out_rt_val, out_cpsr;
  logic        out_writes_rd, out_writes_cpsr, out_is_alu_op, out_is_cmp_op, out_is_ld_op;
  logic [15:0] hazard_stalls;

  operand_read dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd_num(in_rd_num), .in_rs_num(in_rs_num), .in_rt_num(in_rt_num),
    .in_uses_rd(in_uses_rd), .in_uses_rs(in_uses_rs), .in_uses_rt(in_uses_rt),
    .in_uses_cpsr(in_uses_cpsr), .in_writes_rd(in_writes_rd), .in_writes_cpsr(in_writes_cpsr),
    .in_is_alu_op(in_is_alu_op), .in_is_cmp_op(in_is_cmp_op), .in_is_ld_op(in_is_ld_op),
    .exe_rd_num(exe_rd_num), .exe_rs_num(exe_rs_num), .exe_rt_num(exe_rt_num),
    .exe_rd_data_out(exe_rd_data_out), .exe_rs_data_out(exe_rs_data_out),
    .exe_rt_data_out(exe_rt_data_out), .exe_cpsr_out(exe_cpsr_out),
    .wb_rd_num(wb_rd_num), .wb_rd_write_en(wb_rd_write_en), .wb_rd_in(wb_rd_in),
    .wb_cpsr_write_en(wb_cpsr_write_en), .wb_cpsr_in(wb_cpsr_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd_num(out_rd_num),
    .out_rd_val(out_rd_val), .out_rs_val(out_rs_val), .out_rt_val(out_rt_val),
    .out_cpsr(out_cpsr), .out_writes_rd(out_writes_rd), .out_writes_cpsr(out_writes_cpsr),
    .out_is_alu_op(out_is_alu_op), .out_is_cmp_op(out_is_cmp_op), .out_is_ld_op(out_is_ld_op),
    .hazard_stalls(hazard_stalls)
  );

  // regFile model: r[i] = i after reset, written by the writeback port at the edge.
  logic [31:0] rf [16];
  logic [31:0] cpsr_q;
  assign exe_rd_data_out = rf[exe_rd_num];
  assign exe_rs_data_out = rf[exe_rs_num];
  assign exe_rt_data_out = rf[exe_rt_num];
  assign exe_cpsr_out    = cpsr_q;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) rf[i] <= 32'(i);
      cpsr_q <= 32'd0;
    end else begin
      if (wb_rd_write_en)   rf[wb_rd_num] <= wb_rd_in;
      if (wb_cpsr_write_en) cpsr_q        <= wb_cpsr_in;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    {in_rd_num, in_rs_num, in_rt_num} = '0;
    {in_uses_cpsr, in_uses_rt, in_uses_rs, in_uses_rd} = '0;
    {in_writes_cpsr, in_writes_rd} = '0;
    {in_is_ld_op, in_is_cmp_op, in_is_alu_op} = '0;
    wb_rd_write_en = 1'b0; wb_rd_num = '0; wb_rd_in = '0;
    wb_cpsr_write_en = 1'b0; wb_cpsr_in = '0;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    out_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // uses = {cpsr,rt,rs,rd}, writes = {cpsr,rd}, cls = {ld,cmp,alu}
  task automatic drive_op(input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt,
                          input logic [3:0] uses, input logic [1:0] writes, input logic [2:0] cls);
    in_valid = 1'b1;
    in_rd_num = rd; in_rs_num = rs; in_rt_num = rt;
    {in_uses_cpsr, in_uses_rt, in_uses_rs, in_uses_rd} = uses;
    {in_writes_cpsr, in_writes_rd} = writes;
    {in_is_ld_op, in_is_cmp_op, in_is_alu_op} = cls;
  endtask

  // Producer then dependent consumer; writeback arrives two cycles after the producer issues.
  task automatic raw_case(input bit use_cpsr);
    string tag;
    int extra;
    tag = use_cpsr ? "cpsr" : "r3";
    do_reset();
    if (use_cpsr) drive_op(4'd0, 4'd1, 4'd0, 4'b0010, 2'b10, 3'b010);
    else          drive_op(4'd3, 4'd0, 4'd0, 4'b0010, 2'b01, 3'b001);
    tick();
    if (use_cpsr) drive_op(4'd6, 4'd0, 4'd0, 4'b1000, 2'b01, 3'b001);
    else          drive_op(4'd4, 4'd3, 4'd0, 4'b0010, 2'b01, 3'b001);
    #1;
    check({tag, "_stall_behind_held"}, 32'(in_ready), 32'd0);
    tick();
    if (use_cpsr) begin wb_cpsr_write_en = 1'b1; wb_cpsr_in = 32'hA; end
    else begin wb_rd_write_en = 1'b1; wb_rd_num = 4'd3; wb_rd_in = 32'h55; end
    #1;
    check({tag, "_ready_in_wb_cycle"}, 32'(in_ready), 32'(BYP));
    tick();
    wb_rd_write_en = 1'b0; wb_cpsr_write_en = 1'b0;
    extra = 0;
    while (!out_valid && extra < 4) begin
      tick();
      extra++;
    end
    in_valid = 1'b0;
    check({tag, "_extra_cycles"}, 32'(extra), BYP ? 32'd0 : 32'd1);
    check({tag, "_operand"}, use_cpsr ? out_cpsr : out_rs_val, use_cpsr ? 32'hA : 32'h55);
    check({tag, "_stall_count"}, 32'(hazard_stalls), BYP ? 32'd1 : 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset behaviour: in_ready low during reset even with a valid request.
    idle();
    out_ready = 1'b1;
    reset = 1'b1;
    drive_op(4'd1, 4'd1, 4'd0, 4'b0010, 2'b01, 3'b001);
    #1;
    check("ready_during_reset", 32'(in_ready), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    idle();
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_rs_val", out_rs_val, 32'd0);
    check("reset_stalls", 32'(hazard_stalls), 32'd0);

    // 16 independent ALU ops, one per cycle.
    for (int i = 0; i < 16; i++) begin
      drive_op(4'(i), 4'(i), 4'(15 - i), 4'b0010, 2'b01, 3'b001);
      tick();
      check($sformatf("stream_rs_%0d", i), out_rs_val, 32'(i));
      if (i == 9) begin
        check("stream_valid", 32'(out_valid), 32'd1);
        check("stream_rd_val", out_rd_val, 32'd9);
        check("stream_rt_val", out_rt_val, 32'd6);
        check("stream_alu_flag", 32'(out_is_alu_op), 32'd1);
      end
    end
    idle();
    tick();
    check("stream_drain_valid", 32'(out_valid), 32'd0);
    check("stream_stalls", 32'(hazard_stalls), 32'd0);

    // Register and CPSR read-after-write.
    raw_case(1'b0);
    check("r3_dest", 32'(out_rd_num), 32'd4);
    raw_case(1'b1);
    check("cpsr_writes_rd_flag", 32'(out_writes_rd), 32'd1);
    check("cpsr_cmp_flag", 32'(out_is_cmp_op), 32'd0);

    // Backpressure: outputs hold, no stall counted.
    do_reset();
    drive_op(4'd7, 4'd1, 4'd0, 4'b0010, 2'b01, 3'b001);
    tick();
    out_ready = 1'b0;
    drive_op(4'd8, 4'd2, 4'd0, 4'b0010, 2'b01, 3'b001);
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_ready_%0d", k), 32'(in_ready), 32'd0);
      check($sformatf("bp_rd_num_%0d", k), 32'(out_rd_num), 32'd7);
      check($sformatf("bp_rs_val_%0d", k), out_rs_val, 32'd1);
      tick();
    end
    check("bp_stalls", 32'(hazard_stalls), 32'd0);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    idle();
    check("bp_next_rd_num", 32'(out_rd_num), 32'd8);

    // Pending-counter saturation on r2.
    do_reset();
    drive_op(4'd2, 4'd0, 4'd0, 4'b0000, 2'b01, 3'b100);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("ld_accept_%0d", k), 32'(in_ready), 32'd1);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("ld_full_%0d", k), 32'(in_ready), 32'd0);
      tick();
    end
    wb_rd_write_en = 1'b1; wb_rd_num = 4'd2; wb_rd_in = 32'h22;
    #1;
    check("ld_full_wb_cycle", 32'(in_ready), 32'd0);
    tick();
    wb_rd_write_en = 1'b0;
    #1;
    check("ld_accept_after_wb", 32'(in_ready), 32'd1);
    tick();
    idle();
    check("ld_fourth_valid", 32'(out_valid), 32'd1);
    check("ld_fourth_flag", 32'(out_is_ld_op), 32'd1);
    check("ld_stalls", 32'(hazard_stalls), 32'd4);

    // Flush discards the held r5 writer without reserving r5.
    do_reset();
    drive_op(4'd5, 4'd0, 4'd0, 4'b0010, 2'b01, 3'b001);
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    #1;
    check("flush_held_valid", 32'(out_valid), 32'd1);
    check("flush_ready_low", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    drive_op(4'd9, 4'd5, 4'd0, 4'b0010, 2'b01, 3'b001);
    #1;
    check("flush_reader_ready", 32'(in_ready), 32'd1);
    tick();
    idle();
    check("flush_reader_rs_val", out_rs_val, 32'd5);
    check("flush_stalls", 32'(hazard_stalls), 32'd0);

    // Reset clears a reservation; a late writeback must not underflow.
    drive_op(4'd7, 4'd0, 4'd0, 4'b0010, 2'b01, 3'b001);
    tick();
    idle();
    tick();
    do_reset();
    wb_rd_write_en = 1'b1; wb_rd_num = 4'd7; wb_rd_in = 32'h77;
    tick();
    wb_rd_write_en = 1'b0;
    drive_op(4'd10, 4'd7, 4'd0, 4'b0010, 2'b01, 3'b001);
    #1;
    check("post_reset_no_underflow", 32'(in_ready), 32'd1);
    tick();
    idle();
    check("post_reset_rs_val", out_rs_val, 32'h77);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
